// File: rtl/fwd_track_if.sv
// Decode/pipeline-side bus of the forwarding tracker: decode fields, hazard
// controls, stage data in; forwarding vector/data and writeback out.
interface fwd_track_if;
  logic        Dec_valid;
  logic        Dec_regwrite;
  logic        Dec_memtoreg;
  logic        Dec_halt;
  logic [2:0]  Dec_write_reg;
  logic        Stall;
  logic        Flush;
  logic [15:0] Ex_result;
  logic [15:0] Mem_alu;
  logic [15:0] Mem_rdata;
  logic [11:0] Forwarding_vector;
  logic [47:0] Forwarding_data;
  logic        Wb_regwrite;
  logic [2:0]  Wb_write_reg;
  logic [15:0] Wb_data;
  logic        Load_in_ex;
  logic        Halted;

  modport master (
    output Dec_valid, Dec_regwrite, Dec_memtoreg, Dec_halt, Dec_write_reg,
    output Stall, Flush, Ex_result, Mem_alu, Mem_rdata,
    input  Forwarding_vector, Forwarding_data, Wb_regwrite, Wb_write_reg,
    input  Wb_data, Load_in_ex, Halted
  );

  modport slave (
    input  Dec_valid, Dec_regwrite, Dec_memtoreg, Dec_halt, Dec_write_reg,
    input  Stall, Flush, Ex_result, Mem_alu, Mem_rdata,
    output Forwarding_vector, Forwarding_data, Wb_regwrite, Wb_write_reg,
    output Wb_data, Load_in_ex, Halted
  );
endinterface

// File: rtl/fwd_track.sv
// Tracks EX/MEM/WB destination registers and data for operand forwarding.
// Latency: decode enters EX after one edge; outputs are combinational on stage state.
// No backpressure: Stall/Flush inject an EX bubble; a retired HALT freezes all stages.
module fwd_track (
  input  logic       clk,
  input  logic       rst,
  fwd_track_if.slave bus
);
  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memtoreg;
    logic       halt;
    logic [2:0] rg;
  } stage_t;

  stage_t      ex_q, mem_q, dec_s;
  logic        wb_valid_q, wb_regwrite_q;
  logic [2:0]  wb_reg_q;
  logic [15:0] wb_data_q;
  logic        halted_q;
  logic        take_dec;
  logic [15:0] mem_data;
  logic        v0, v1, v2;

  assign take_dec = bus.Dec_valid & ~bus.Stall & ~bus.Flush;

  // Anything not accepted from decode becomes an all-zero bubble.
  always_comb begin
    dec_s = '0;
    if (take_dec) begin
      dec_s.valid    = 1'b1;
      dec_s.regwrite = bus.Dec_regwrite;
      dec_s.memtoreg = bus.Dec_memtoreg;
      dec_s.halt     = bus.Dec_halt;
      dec_s.rg       = bus.Dec_write_reg;
    end
  end

  assign mem_data = mem_q.memtoreg ? bus.Mem_rdata : bus.Mem_alu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_reg_q      <= 3'd0;
      wb_data_q     <= 16'h0000;
      halted_q      <= 1'b0;
    end else if (!halted_q) begin
      ex_q          <= dec_s;
      mem_q         <= ex_q;
      wb_valid_q    <= mem_q.valid;
      wb_regwrite_q <= mem_q.regwrite;
      wb_reg_q      <= mem_q.rg;
      wb_data_q     <= mem_data;
      halted_q      <= mem_q.valid & mem_q.halt;
    end
  end

  // Loads in EX have no data yet, so v0 excludes them while r0 stays visible.
  assign v0 = ~halted_q & ex_q.valid & ex_q.regwrite & ~ex_q.memtoreg;
  assign v1 = ~halted_q & mem_q.valid & mem_q.regwrite;
  assign v2 = ~halted_q & wb_valid_q & wb_regwrite_q;

  assign bus.Forwarding_vector = halted_q ? 12'h000
                                          : {v2, wb_reg_q, v1, mem_q.rg, v0, ex_q.rg};
  assign bus.Forwarding_data   = {wb_data_q, mem_data, bus.Ex_result};
  assign bus.Wb_regwrite       = v2;
  assign bus.Wb_write_reg      = halted_q ? 3'd0 : wb_reg_q;
  assign bus.Wb_data           = wb_data_q;
  assign bus.Load_in_ex        = ~halted_q & ex_q.valid & ex_q.memtoreg;
  assign bus.Halted            = halted_q;
endmodule

// File: tb/tb_fwd_track.sv
// Self-checking bench for fwd_track: directed table, halt/reset sequences, random vs model.
module tb_fwd_track;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_track_if bus();
  fwd_track dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic mtr, input logic h,
                       input logic [2:0] rg, input logic st, input logic fl,
                       input logic [15:0] exr, input logic [15:0] alu, input logic [15:0] rd);
    bus.Dec_valid     = v;
    bus.Dec_regwrite  = rw;
    bus.Dec_memtoreg  = mtr;
    bus.Dec_halt      = h;
    bus.Dec_write_reg = rg;
    bus.Stall         = st;
    bus.Flush         = fl;
    bus.Ex_result     = exr;
    bus.Mem_alu       = alu;
    bus.Mem_rdata     = rd;
  endtask

  task automatic edge_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed table: inputs applied across one edge, expected outputs after it.
  typedef struct {
    logic v, rw, mtr, h; logic [2:0] rg; logic st, fl;
    logic [15:0] exr, alu, rd;
    logic [11:0] e_vec; logic e_ld, e_wbre; logic [2:0] e_wbreg;
    logic [15:0] e_wbd, e_f31;
  } vec_t;
  vec_t tbl [9];

  // Behavioural reference: index 0=EX, 1=MEM, 2=WB.
  typedef struct packed {
    logic valid, rw, mtr, h; logic [2:0] rg; logic [15:0] data;
  } ent_t;
  ent_t pipe [3];
  logic m_halted;

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      pipe[2]      = pipe[1];
      pipe[2].data = pipe[1].mtr ? bus.Mem_rdata : bus.Mem_alu;
      pipe[1]      = pipe[0];
      pipe[0]      = '0;
      if (bus.Dec_valid && !bus.Stall && !bus.Flush)
        pipe[0] = '{1'b1, bus.Dec_regwrite, bus.Dec_memtoreg, bus.Dec_halt,
                    bus.Dec_write_reg, 16'h0000};
      m_halted = pipe[2].valid && pipe[2].h;
    end
  endtask

  function automatic logic [11:0] m_vec();
    if (m_halted) return 12'h000;
    return {pipe[2].valid & pipe[2].rw, pipe[2].rg,
            pipe[1].valid & pipe[1].rw, pipe[1].rg,
            pipe[0].valid & pipe[0].rw & ~pipe[0].mtr, pipe[0].rg};
  endfunction

  initial begin
    logic [11:0] ev;
    int halt_cnt;
    logic [15:0] frozen;

    tbl[0] = '{1'b1,1'b1,1'b0,1'b0,3'd3,1'b0,1'b0,16'h1234,16'h0000,16'h0000,12'h00B,1'b0,1'b0,3'd0,16'h0000,16'h0000};
    tbl[1] = '{1'b1,1'b1,1'b1,1'b0,3'd5,1'b0,1'b0,16'h0010,16'h1234,16'hBEEF,12'h0B5,1'b1,1'b0,3'd0,16'h1234,16'h1234};
    tbl[2] = '{1'b1,1'b1,1'b0,1'b0,3'd2,1'b1,1'b0,16'h0002,16'h1234,16'hBEEF,12'hBD0,1'b0,1'b1,3'd3,16'h1234,16'hBEEF};
    tbl[3] = '{1'b1,1'b1,1'b0,1'b0,3'd6,1'b1,1'b1,16'h0003,16'h0777,16'hCAFE,12'hD00,1'b0,1'b1,3'd5,16'hCAFE,16'h0777};
    tbl[4] = '{1'b1,1'b1,1'b0,1'b0,3'd7,1'b0,1'b1,16'h0004,16'h0001,16'h0002,12'h000,1'b0,1'b0,3'd0,16'h0001,16'h0001};
    tbl[5] = '{1'b0,1'b1,1'b0,1'b0,3'd4,1'b0,1'b0,16'h0005,16'h00AA,16'h00BB,12'h000,1'b0,1'b0,3'd0,16'h00AA,16'h00AA};
    tbl[6] = '{1'b1,1'b1,1'b0,1'b0,3'd0,1'b0,1'b0,16'h5555,16'h0000,16'h0000,12'h008,1'b0,1'b0,3'd0,16'h0000,16'h0000};
    tbl[7] = '{1'b1,1'b0,1'b0,1'b0,3'd7,1'b0,1'b0,16'h0006,16'h0042,16'h0099,12'h087,1'b0,1'b0,3'd0,16'h0042,16'h0042};
    tbl[8] = '{1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,1'b0,16'h0007,16'h0123,16'h0000,12'h870,1'b0,1'b1,3'd0,16'h0123,16'h0123};

    rst = 1'b1;
    drive(1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,1'b0,16'h0,16'h0,16'h0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_vec",    64'(bus.Forwarding_vector), 64'h0);
    chk("reset_wb",     64'({bus.Wb_regwrite, bus.Wb_write_reg, bus.Wb_data}), 64'h0);
    chk("reset_ld_hlt", 64'({bus.Load_in_ex, bus.Halted}), 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].rw, tbl[i].mtr, tbl[i].h, tbl[i].rg, tbl[i].st, tbl[i].fl,
            tbl[i].exr, tbl[i].alu, tbl[i].rd);
      edge_step();
      chk($sformatf("tbl%0d_vec", i), 64'(bus.Forwarding_vector), 64'(tbl[i].e_vec));
      chk($sformatf("tbl%0d_wb", i), 64'({bus.Wb_regwrite, bus.Wb_write_reg, bus.Wb_data}),
          64'({tbl[i].e_wbre, tbl[i].e_wbreg, tbl[i].e_wbd}));
      chk($sformatf("tbl%0d_fdata", i), 64'(bus.Forwarding_data),
          64'({tbl[i].e_wbd, tbl[i].e_f31, tbl[i].exr}));
      chk($sformatf("tbl%0d_ld_hlt", i), 64'({bus.Load_in_ex, bus.Halted}),
          64'({tbl[i].e_ld, 1'b0}));
    end

    // HALT then ADDs: Halted rises on the third edge, everything then freezes.
    do_reset();
    drive(1'b1,1'b0,1'b0,1'b1,3'd0,1'b0,1'b0,16'h0001,16'h0AAA,16'h0000);
    edge_step();
    chk("halt_e1", 64'({bus.Halted, bus.Forwarding_vector}), 64'h0);
    drive(1'b1,1'b1,1'b0,1'b0,3'd1,1'b0,1'b0,16'h0002,16'h0BBB,16'h0000);
    edge_step();
    chk("halt_e2", 64'({bus.Halted, bus.Forwarding_vector}), 64'h009);
    drive(1'b1,1'b1,1'b0,1'b0,3'd2,1'b0,1'b0,16'h0003,16'h0CCC,16'h0000);
    edge_step();
    chk("halt_e3", 64'({bus.Halted, bus.Forwarding_vector, bus.Wb_regwrite, bus.Load_in_ex}),
        64'({1'b1, 12'h000, 1'b0, 1'b0}));
    chk("halt_e3_wbd", 64'(bus.Wb_data), 64'h0CCC);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1,1'b1,1'b0,1'b0,3'(i + 3),1'b0,1'b0,16'h0004,16'($urandom),16'($urandom));
      edge_step();
      chk($sformatf("halt_frozen%0d", i),
          64'({bus.Halted, bus.Forwarding_vector, bus.Wb_regwrite, bus.Wb_data}),
          64'({1'b1, 12'h000, 1'b0, 16'h0CCC}));
    end

    // All three slots valid, then asynchronous reset mid-cycle during stall+flush.
    do_reset();
    chk("post_halt_rst", 64'({bus.Halted, bus.Forwarding_vector}), 64'h0);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1,1'b1,1'b0,1'b0,3'(i),1'b0,1'b0,16'h0100,16'h1111,16'h2222);
      edge_step();
    end
    chk("full_vec", 64'(bus.Forwarding_vector), 64'h9AB);
    chk("full_wb", 64'({bus.Wb_regwrite, bus.Wb_write_reg, bus.Wb_data}),
        64'({1'b1, 3'd1, 16'h1111}));
    bus.Stall = 1'b1;
    bus.Flush = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vec", 64'(bus.Forwarding_vector), 64'h0);
    chk("async_rst_wb", 64'({bus.Wb_regwrite, bus.Wb_data, bus.Halted}), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized run against the behavioural model.
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_halted = 1'b0;
    halt_cnt = 0;
    frozen = 16'h0;
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 49) == 0) || (m_halted && halt_cnt > 6);
      drive(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 29) == 0), 3'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            16'($urandom), 16'($urandom), 16'($urandom));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      halt_cnt = m_halted ? halt_cnt + 1 : 0;
      ev = m_vec();
      chk("rnd_vec", 64'(bus.Forwarding_vector), 64'(ev));
      chk("rnd_wb", 64'({bus.Wb_regwrite, bus.Wb_write_reg, bus.Wb_data}),
          64'({ev[11], ev[10:8], pipe[2].data}));
      chk("rnd_fdata", 64'(bus.Forwarding_data),
          64'({pipe[2].data, (pipe[1].mtr ? bus.Mem_rdata : bus.Mem_alu), bus.Ex_result}));
      chk("rnd_ld_hlt", 64'({bus.Load_in_ex, bus.Halted}),
          64'({~m_halted & pipe[0].valid & pipe[0].mtr, m_halted}));
      frozen = bus.Wb_data;
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
